param_access_sequencer: RTL and testbench
=========================================

Name: param_access_sequencer

Overview:
- Parametrised password gate in front of the game datapath: collects NUM_DIGITS digits of DIGIT_W bits each and compares them against a word supplied by the password ROM.
- On a match, sequences reconfig -> game start -> gameplay -> game over, passing the player buttons through only during gameplay.
- Adds what the fixed 4-digit controller lacks:
  - generic digit count and width;
  - same-cycle compare, with no stale-flag pass;
  - bounded retry count followed by a timed lockout;
  - explicit reset of every output.

Parameters:
- DIGIT_W, 4, bits per entered digit.
- NUM_DIGITS, 4, digits per password; must be ≥1.
- ROM_LATENCY, 2, wait cycles after the last digit before compare; 0 is legal and means compare on the next cycle.
- MAX_ATTEMPTS, 3, consecutive failures before lockout; must be ≥1.
- LOCKOUT_CYCLES, 1000, clock cycles spent in lockout; must be ≥1.
- ENTRY_TIMEOUT_CYCLES, 5000, idle cycles allowed between digits; used only with ACCESS_ENTRY_TIMEOUT_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- digit_in  in  DIGIT_W  digit value, sampled when digit_enter=1.
- digit_enter  in  1  one-cycle debounced enter pulse.
- rom_data  in  DIGIT_W*NUM_DIGITS  stored password, first digit in the MSBs.
- random_button  in  1  RNG button, active-low.
- player_input_button  in  1  load button, active-low.
- timeout  in  1  game timer expiry.
- output_to_rng  out  1  gated random_button.
- output_to_load_reg  out  1  gated player_input_button.
- RedLED  out  1  status LED.
- GreenLED  out  1  status LED.
- enable  out  1  game enable, level.
- reconfig  out  1  one-cycle reconfig pulse.
- locked  out  1  high while in lockout.
- attempts_left  out  $clog2(MAX_ATTEMPTS+1)  remaining tries before lockout.

Behaviour:
- Reset is synchronous and active-low, on clock. While reset=0, outputs are forced to: output_to_rng=1, output_to_load_reg=0, RedLED=1, GreenLED=1, enable=0, reconfig=0, locked=0, attempts_left=MAX_ATTEMPTS. Also: digit index=0, entry register=0, state=ENTRY. Reset mid-operation, including in GAMEPLAY or LOCKOUT, returns to these values on the next edge.
- Outside GAMEPLAY: output_to_rng=1 and output_to_load_reg=0 (idle button levels).
- ENTRY:
  - RedLED=1, GreenLED=0.
  - Each digit_enter stores digit_in into slot (NUM_DIGITS-1-idx) and increments idx.
  - When the last digit is stored, idx clears and the FSM goes to WAIT (ROM_LATENCY>0) or CHECK (ROM_LATENCY=0).
- WAIT: counts ROM_LATENCY cycles, then goes to CHECK. digit_enter is ignored.
- CHECK (one cycle):
  - Compares the entry register with rom_data in the same cycle.
  - Match: attempts_left reloads to MAX_ATTEMPTS; next state SUCCESS.
  - Mismatch: attempts_left decrements. If it becomes 0, go to LOCKOUT; otherwise go to ENTRY.
  - The entry register is cleared on exit.
- LOCKOUT:
  - locked=1, RedLED=1, GreenLED=0; digit_enter is ignored.
  - After LOCKOUT_CYCLES cycles: locked=0, attempts_left=MAX_ATTEMPTS, go to ENTRY.
- SUCCESS: RedLED=0, GreenLED=1; go to RECONFIG next cycle.
- RECONFIG: on digit_enter, reconfig=1 for exactly one cycle; go to GAMESTART.
- GAMESTART: on digit_enter, enable=1; go to GAMEPLAY.
- GAMEPLAY:
  - output_to_rng and output_to_load_reg are registered copies of random_button and player_input_button, so they lag by one cycle.
  - timeout=1 goes to GAMEOVER.
  - timeout is sampled only in this state.
- GAMEOVER:
  - enable=0, RedLED=1, GreenLED=0.
  - Held until reset.
- Any unused state encoding recovers to ENTRY.
- If digit_enter and timeout occur in the same cycle, each is honoured only in its own state.

Optional Feature:
- Macro: ACCESS_ENTRY_TIMEOUT_EN.
- Defined:
  - An idle counter runs in ENTRY whenever idx≠0.
  - It is cleared by every digit_enter.
  - If it reaches ENTRY_TIMEOUT_CYCLES, the partial entry is discarded (idx=0, entry register=0) and the FSM stays in ENTRY.
  - This is not counted as a failed attempt.
- Undefined: no counter is built; a partial entry waits indefinitely.

Test Plan:
- All cases use DIGIT_W=4, NUM_DIGITS=4, ROM_LATENCY=2, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=16, rom_data=16'h2949.
- Correct entry: enter 2,9,4,9 -> CHECK occurs 3 cycles after the 4th pulse; then SUCCESS with RedLED=0, GreenLED=1, attempts_left=3.
- Wrong entry: enter 2,9,4,8 -> back to ENTRY with attempts_left=2 and RedLED=1. A following correct entry succeeds and reloads attempts_left=3.
- Lockout: three wrong entries -> locked=1 for exactly 16 cycles. A digit_enter during lockout has no effect. Afterwards locked=0 and attempts_left=3.
- Game sequence: success, then digit_enter -> reconfig high exactly 1 cycle. Second digit_enter -> enable=1. random_button=0 -> output_to_rng=0 one cycle later. timeout=1 -> enable=0, RedLED=1, GreenLED=0, held.
- Reset: assert reset=0 in GAMEPLAY with enable=1 -> all outputs at their reset values on the next edge. A fresh 2,9,4,9 entry succeeds.
- Feature (ACCESS_ENTRY_TIMEOUT_EN, ENTRY_TIMEOUT_CYCLES=8): enter 2,9, idle 8 cycles, then enter 4,9,2,9 -> fails with attempts_left=2; entering 2,9,4,9 instead succeeds.

Source files
------------

// File: rtl/param_access_sequencer.sv
// Password gate ahead of the game datapath: digit entry, ROM compare, retry/lockout, then game sequencing.
// Build macro ACCESS_ENTRY_TIMEOUT_EN adds an idle timeout that discards a partial entry.
module param_access_sequencer #(
    parameter int DIGIT_W              = 4,
    parameter int NUM_DIGITS           = 4,
    parameter int ROM_LATENCY          = 2,
    parameter int MAX_ATTEMPTS         = 3,
    parameter int LOCKOUT_CYCLES       = 1000,
    parameter int ENTRY_TIMEOUT_CYCLES = 5000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              digit_enter,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]     rom_data,
    input  logic                              random_button,
    input  logic                              player_input_button,
    input  logic                              timeout,
    output logic                              output_to_rng,
    output logic                              output_to_load_reg,
    output logic                              RedLED,
    output logic                              GreenLED,
    output logic                              enable,
    output logic                              reconfig,
    output logic                              locked,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left
);
    localparam int ENTRY_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int WAIT_W  = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam int LOCK_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int AW      = $clog2(MAX_ATTEMPTS + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ROM_LATENCY > 0) ? ROM_LATENCY - 1 : 0);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [AW-1:0]     ATT_MAX   = AW'(MAX_ATTEMPTS);

    if (NUM_DIGITS < 1 || MAX_ATTEMPTS < 1 || LOCKOUT_CYCLES < 1 || ENTRY_TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("param_access_sequencer: NUM_DIGITS, MAX_ATTEMPTS, LOCKOUT_CYCLES and ENTRY_TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [3:0] {
        ST_ENTRY     = 4'd0,
        ST_WAIT      = 4'd1,
        ST_CHECK     = 4'd2,
        ST_LOCKOUT   = 4'd3,
        ST_SUCCESS   = 4'd4,
        ST_RECONFIG  = 4'd5,
        ST_GAMESTART = 4'd6,
        ST_GAMEPLAY  = 4'd7,
        ST_GAMEOVER  = 4'd8
    } state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [ENTRY_W-1:0]  entry_reg, entry_next, entry_loaded;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_next;
    logic [LOCK_W-1:0]   lock_cnt_reg, lock_next;
    logic [AW-1:0]       attempts_reg, attempts_next;
    logic                reconfig_next, game_side;
    logic                rng_next, load_next, red_next, green_next, enable_next, locked_next;

    // The digit at index idx lands in slot NUM_DIGITS-1-idx so the first digit ends up in the MSBs.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign entry_loaded[gi*DIGIT_W +: DIGIT_W] =
                (idx_reg == IDX_W'(NUM_DIGITS - 1 - gi)) ? digit_in : entry_reg[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

`ifdef ACCESS_ENTRY_TIMEOUT_EN
    localparam int IDLE_W = (ENTRY_TIMEOUT_CYCLES > 1) ? $clog2(ENTRY_TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(ENTRY_TIMEOUT_CYCLES - 1);
    logic [IDLE_W-1:0] idle_cnt_reg, idle_next;
`endif

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        entry_next    = entry_reg;
        wait_next     = wait_cnt_reg;
        lock_next     = lock_cnt_reg;
        attempts_next = attempts_reg;
        reconfig_next = 1'b0;
        case (state_reg)
            ST_ENTRY: begin
                if (digit_enter) begin
                    entry_next = entry_loaded;
                    if (idx_reg == IDX_LAST) begin
                        idx_next   = '0;
                        wait_next  = '0;
                        state_next = (ROM_LATENCY > 0) ? ST_WAIT : ST_CHECK;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) state_next = ST_CHECK;
                else                           wait_next  = wait_cnt_reg + WAIT_W'(1);
            end
            ST_CHECK: begin
                // rom_data is compared against the entry in this very cycle; no flag carried over.
                entry_next = '0;
                if (entry_reg == rom_data) begin
                    attempts_next = ATT_MAX;
                    state_next    = ST_SUCCESS;
                end else if (attempts_reg <= AW'(1)) begin
                    attempts_next = '0;
                    lock_next     = '0;
                    state_next    = ST_LOCKOUT;
                end else begin
                    attempts_next = attempts_reg - AW'(1);
                    state_next    = ST_ENTRY;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_reg == LOCK_LAST) begin
                    attempts_next = ATT_MAX;
                    state_next    = ST_ENTRY;
                end else begin
                    lock_next = lock_cnt_reg + LOCK_W'(1);
                end
            end
            ST_SUCCESS:   state_next = ST_RECONFIG;
            ST_RECONFIG: begin
                if (digit_enter) begin
                    reconfig_next = 1'b1;
                    state_next    = ST_GAMESTART;
                end
            end
            ST_GAMESTART: if (digit_enter) state_next = ST_GAMEPLAY;
            ST_GAMEPLAY:  if (timeout)     state_next = ST_GAMEOVER;
            ST_GAMEOVER:  state_next = ST_GAMEOVER;
            default: begin
                state_next = ST_ENTRY;
                idx_next   = '0;
                entry_next = '0;
            end
        endcase

`ifdef ACCESS_ENTRY_TIMEOUT_EN
        idle_next = '0;
        if (state_reg == ST_ENTRY && !digit_enter && idx_reg != '0) begin
            if (idle_cnt_reg == IDLE_LAST) begin
                idx_next   = '0;
                entry_next = '0;
            end else begin
                idle_next = idle_cnt_reg + IDLE_W'(1);
            end
        end
`endif

        // Outputs are registered from the next state so they line up with the state they describe.
        game_side   = state_next inside {ST_SUCCESS, ST_RECONFIG, ST_GAMESTART, ST_GAMEPLAY};
        red_next    = !game_side;
        green_next  = game_side;
        enable_next = (state_next == ST_GAMEPLAY);
        locked_next = (state_next == ST_LOCKOUT);
        rng_next    = (state_next == ST_GAMEPLAY) ? random_button : 1'b1;
        load_next   = (state_next == ST_GAMEPLAY) ? player_input_button : 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg          <= ST_ENTRY;
            idx_reg            <= '0;
            entry_reg          <= '0;
            wait_cnt_reg       <= '0;
            lock_cnt_reg       <= '0;
            attempts_reg       <= ATT_MAX;
            output_to_rng      <= 1'b1;
            output_to_load_reg <= 1'b0;
            RedLED             <= 1'b1;
            GreenLED           <= 1'b1;
            enable             <= 1'b0;
            reconfig           <= 1'b0;
            locked             <= 1'b0;
`ifdef ACCESS_ENTRY_TIMEOUT_EN
            idle_cnt_reg       <= '0;
`endif
        end else begin
            state_reg          <= state_next;
            idx_reg            <= idx_next;
            entry_reg          <= entry_next;
            wait_cnt_reg       <= wait_next;
            lock_cnt_reg       <= lock_next;
            attempts_reg       <= attempts_next;
            output_to_rng      <= rng_next;
            output_to_load_reg <= load_next;
            RedLED             <= red_next;
            GreenLED           <= green_next;
            enable             <= enable_next;
            reconfig           <= reconfig_next;
            locked             <= locked_next;
`ifdef ACCESS_ENTRY_TIMEOUT_EN
            idle_cnt_reg       <= idle_next;
`endif
        end
    end

    assign attempts_left = attempts_reg;

endmodule

// File: tb/tb_param_access_sequencer.sv
// Directed and randomized bench for param_access_sequencer, checked every cycle against a behavioural model.
// The idle-timeout scenario runs only when ACCESS_ENTRY_TIMEOUT_EN is defined.
module tb_param_access_sequencer;
    localparam int DW = 4, ND = 4, LAT = 2, MAXA = 3, LOCKC = 16, TMO = 8;
    localparam logic [15:0] ROM = 16'h2949;

    logic        clock = 1'b0;
    logic        reset, digit_enter, random_button, player_input_button, timeout;
    logic [3:0]  digit_in;
    logic [15:0] rom_data;
    logic        output_to_rng, output_to_load_reg, RedLED, GreenLED, enable, reconfig, locked;
    logic [1:0]  attempts_left;

    always #5 clock = ~clock;

    param_access_sequencer #(
        .DIGIT_W(DW), .NUM_DIGITS(ND), .ROM_LATENCY(LAT), .MAX_ATTEMPTS(MAXA),
        .LOCKOUT_CYCLES(LOCKC), .ENTRY_TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .digit_in(digit_in), .digit_enter(digit_enter),
        .rom_data(rom_data), .random_button(random_button),
        .player_input_button(player_input_button), .timeout(timeout),
        .output_to_rng(output_to_rng), .output_to_load_reg(output_to_load_reg),
        .RedLED(RedLED), .GreenLED(GreenLED), .enable(enable), .reconfig(reconfig),
        .locked(locked), .attempts_left(attempts_left)
    );

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: digits collected in a queue, plain countdowns for ROM wait and lockout.
    typedef enum int {M_COLLECT, M_ROMWAIT, M_COMPARE, M_LOCKED, M_WIN, M_RECONF, M_START, M_PLAY, M_OVER} phase_t;
    phase_t     m_phase = M_COLLECT;
    int         m_digits[$];
    int         m_value = 0, m_wait = 0, m_lock = 0, m_att = MAXA, m_idle = 0;
    bit         m_valid = 1'b0;
    logic       e_rng, e_load, e_red, e_green, e_en, e_rc, e_lk;
    logic [1:0] e_att;

    task automatic model_step();
        if (!reset) begin
            m_phase = M_COLLECT; m_digits.delete(); m_att = MAXA; m_idle = 0;
            e_rng = 1; e_load = 0; e_red = 1; e_green = 1; e_en = 0; e_rc = 0; e_lk = 0;
            e_att = 2'(MAXA);
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        e_rc = 0;
        case (m_phase)
            M_COLLECT: begin
                if (digit_enter) begin
                    m_digits.push_back(int'(digit_in));
                    m_idle = 0;
                    if (m_digits.size() == ND) begin
                        m_value = 0;
                        foreach (m_digits[i]) m_value = m_value * 16 + m_digits[i];
                        m_digits.delete();
                        if (LAT > 0) begin m_phase = M_ROMWAIT; m_wait = LAT; end
                        else m_phase = M_COMPARE;
                    end
                end
`ifdef ACCESS_ENTRY_TIMEOUT_EN
                else if (m_digits.size() > 0) begin
                    m_idle++;
                    if (m_idle >= TMO) begin m_digits.delete(); m_idle = 0; end
                end
`endif
            end
            M_ROMWAIT: begin
                m_wait--;
                if (m_wait == 0) m_phase = M_COMPARE;
            end
            M_COMPARE: begin
                if (m_value == int'(ROM)) begin m_att = MAXA; m_phase = M_WIN; end
                else begin
                    m_att--;
                    if (m_att == 0) begin m_phase = M_LOCKED; m_lock = LOCKC; end
                    else m_phase = M_COLLECT;
                end
                $display("attempt code=%04h match=%0d attempts_left=%0d t=%0t",
                         m_value, m_value == int'(ROM), m_att, $time);
            end
            M_LOCKED: begin
                m_lock--;
                if (m_lock == 0) begin m_att = MAXA; m_phase = M_COLLECT; end
            end
            M_WIN:    m_phase = M_RECONF;
            M_RECONF: if (digit_enter) begin e_rc = 1; m_phase = M_START; end
            M_START:  if (digit_enter) m_phase = M_PLAY;
            M_PLAY:   if (timeout) m_phase = M_OVER;
            default:  m_phase = M_OVER;
        endcase
        e_lk    = (m_phase == M_LOCKED);
        e_en    = (m_phase == M_PLAY);
        e_green = m_phase inside {M_WIN, M_RECONF, M_START, M_PLAY};
        e_red   = !e_green;
        e_rng   = (m_phase == M_PLAY) ? random_button : 1'b1;
        e_load  = (m_phase == M_PLAY) ? player_input_button : 1'b0;
        e_att   = 2'(m_att);
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Every cycle after the first reset edge, all outputs must match the model.
    initial forever begin
        @(negedge clock);
        if (m_valid) begin
            check("rng", output_to_rng, e_rng);
            check("load", output_to_load_reg, e_load);
            check("red", RedLED, e_red);
            check("green", GreenLED, e_green);
            check("enable", enable, e_en);
            check("reconfig", reconfig, e_rc);
            check("locked", locked, e_lk);
            check("attempts", attempts_left, e_att);
        end
    end

    task automatic drive(input logic de, input logic [3:0] d, input logic to_);
        digit_enter = de; digit_in = d; timeout = to_;
        @(negedge clock);
        digit_enter = 1'b0; timeout = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic enter_code(input logic [15:0] code);
        logic [3:0] d;
        for (int i = 0; i < ND; i++) begin
            d = code[4*(ND-1-i) +: 4];
            drive(1'b1, d, 1'b0);
        end
        $display("entered code %04h at %0t", code, $time);
    endtask

    function automatic logic [3:0] rom_nib(input int k);
        logic [15:0] r;
        r = ROM;
        return r[4*(ND-1-k) +: 4];
    endfunction

    initial begin
        int lock_count;
        logic [3:0] d;
        reset = 1'b0; digit_enter = 1'b0; digit_in = 4'h0; timeout = 1'b0;
        random_button = 1'b1; player_input_button = 1'b1; rom_data = ROM;
        @(negedge clock);
        idle(2);
        check("reset_red", RedLED, 1);
        check("reset_green", GreenLED, 1);
        check("reset_attempts", attempts_left, 3);
        check("reset_enable", enable, 0);
        reset = 1'b1;
        idle(1);
        check("entry_green", GreenLED, 0);

        // Correct entry: CHECK three cycles after the 4th pulse, SUCCESS on the fourth.
        enter_code(16'h2949);
        idle(2);
        check("check_cycle_green", GreenLED, 0);
        idle(1);
        check("success_green", GreenLED, 1);
        check("success_red", RedLED, 0);
        check("success_attempts", attempts_left, 3);

        // Game sequence
        idle(1);
        drive(1'b1, 4'h0, 1'b0);
        check("reconfig_pulse", reconfig, 1);
        idle(1);
        check("reconfig_single", reconfig, 0);
        drive(1'b1, 4'h0, 1'b0);
        check("game_enable", enable, 1);
        random_button = 1'b0;
        idle(1);
        check("rng_lag", output_to_rng, 0);
        random_button = 1'b1; player_input_button = 1'b0;
        idle(1);
        check("load_pressed", output_to_load_reg, 0);
        player_input_button = 1'b1;
        idle(1);
        check("load_released", output_to_load_reg, 1);
        drive(1'b0, 4'h0, 1'b1);
        check("over_enable", enable, 0);
        check("over_red", RedLED, 1);
        drive(1'b1, 4'h0, 1'b1);
        idle(4);
        check("over_held_green", GreenLED, 0);
        $display("game sequence done at %0t", $time);
        reset = 1'b0; idle(1); reset = 1'b1; idle(1);

        // Wrong entry then correct entry
        enter_code(16'h2948);
        idle(3);
        check("wrong_attempts", attempts_left, 2);
        check("wrong_red", RedLED, 1);
        enter_code(16'h2949);
        idle(3);
        check("retry_attempts", attempts_left, 3);
        check("retry_green", GreenLED, 1);

        // Reset in gameplay
        idle(1);
        drive(1'b1, 4'h0, 1'b0);
        drive(1'b1, 4'h0, 1'b0);
        check("play_enable", enable, 1);
        reset = 1'b0;
        idle(1);
        check("rst_enable", enable, 0);
        check("rst_green", GreenLED, 1);
        check("rst_rng", output_to_rng, 1);
        check("rst_attempts", attempts_left, 3);
        reset = 1'b1;
        idle(1);

        // Lockout: three failures, pulses during lockout ignored
        enter_code(16'h1111); idle(3);
        enter_code(16'h1111); idle(3);
        check("two_fail_attempts", attempts_left, 1);
        enter_code(16'h1111); idle(2);
        lock_count = 0;
        for (int i = 0; i < 30; i++) begin
            drive((i >= 1 && i <= 12 && (i % 3) == 1), 4'h2, 1'b0);
            if (locked === 1'b1) lock_count++;
        end
        check("lockout_len", lock_count, LOCKC);
        check("post_lock_locked", locked, 0);
        check("post_lock_attempts", attempts_left, 3);
        enter_code(16'h2949); idle(3);
        check("post_lock_success", GreenLED, 1);
        $display("lockout lasted %0d cycles", lock_count);
        reset = 1'b0; idle(1); reset = 1'b1; idle(1);

`ifdef ACCESS_ENTRY_TIMEOUT_EN
        drive(1'b1, 4'h2, 1'b0); drive(1'b1, 4'h9, 1'b0);
        idle(8);
        enter_code(16'h4929); idle(3);
        check("timeout_discard_attempts", attempts_left, 2);
        drive(1'b1, 4'h2, 1'b0); drive(1'b1, 4'h9, 1'b0);
        idle(7);
        drive(1'b1, 4'h4, 1'b0); drive(1'b1, 4'h9, 1'b0);
        idle(3);
        check("timeout_edge_success", GreenLED, 1);
        reset = 1'b0; idle(1); reset = 1'b1; idle(1);
`endif

        // Randomized phase, biased toward correct digits so every phase is reached
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0 ||
                     (m_phase == M_OVER && $urandom_range(0, 19) == 0)) ? 1'b0 : 1'b1;
            random_button       = 1'($urandom_range(0, 1));
            player_input_button = 1'($urandom_range(0, 1));
            if (m_digits.size() < ND && $urandom_range(0, 3) != 0) d = rom_nib(m_digits.size());
            else d = 4'($urandom_range(0, 15));
            drive($urandom_range(0, 2) == 0, d, $urandom_range(0, 15) == 0);
        end
        $display("random phase done at %0t", $time);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
